vga_draw_arbiter: RTL and testbench

//  Parametrised N-client arbiter that owns the single VGA framebuffer write port.

---
 rtl/vga_draw_arbiter_pkg.sv | 10 +
 rtl/vga_draw_arbiter_if.sv | 29 ++
 rtl/vga_draw_arbiter_rr_pick.sv | 25 ++
 rtl/vga_draw_arbiter.sv | 82 ++++++++
 tb/tb_vga_draw_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/vga_draw_arbiter_pkg.sv
// vga_draw_arbiter_pkg: shared FSM states, drawing-client widths and index helper
package vga_draw_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, STARTUP, ARB, GRANT} draw_state_t;
  localparam int DRAW_X_W = 11;
  localparam int DRAW_Y_W = 11;
  localparam int DRAW_COLOR_W = 1;
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/vga_draw_arbiter_if.sv
// vga_draw_arbiter_if: client request/pixel bus and framebuffer write port bundle
interface vga_draw_arbiter_if #(
  parameter int N_CLIENTS = 4,
  parameter int X_W = 11,
  parameter int Y_W = 11,
  parameter int COLOR_W = 1
);
  logic [N_CLIENTS-1:0] req;
  logic [N_CLIENTS-1:0] done;
  logic [N_CLIENTS-1:0] valid;
  logic [N_CLIENTS*X_W-1:0] x_in;
  logic [N_CLIENTS*Y_W-1:0] y_in;
  logic [N_CLIENTS*COLOR_W-1:0] color_in;
  logic [N_CLIENTS-1:0] grant;
  logic [$clog2(N_CLIENTS)-1:0] owner;
  logic busy;
  logic pix_we;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic [COLOR_W-1:0] pix_color;
  modport master (
    output req, done, valid, x_in, y_in, color_in,
    input grant, owner, busy, pix_we, pix_x, pix_y, pix_color
  );
  modport slave (
    input req, done, valid, x_in, y_in, color_in,
    output grant, owner, busy, pix_we, pix_x, pix_y, pix_color
  );
endinterface

// File: rtl/vga_draw_arbiter_rr_pick.sv
// vga_draw_arbiter_rr_pick: first requester at or after ptr, wrapping modulo N
module vga_draw_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] j;
  // Scan farthest-first so the closest requester to ptr wins last.
  always_comb begin
    found_o = 1'b0;
    idx_o = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (req_i[j]) begin
        found_o = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: grants the framebuffer write port to one drawing client at a time
module vga_draw_arbiter
  import vga_draw_arbiter_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int X_W = DRAW_X_W,
  parameter int Y_W = DRAW_Y_W,
  parameter int COLOR_W = DRAW_COLOR_W,
  parameter int STARTUP_CLIENT = 0
) (
  input logic clk,
  input logic reset,
  input logic start_i,
  vga_draw_arbiter_if.slave dbus
);
  localparam int IW = $clog2(N_CLIENTS);
  draw_state_t state_q;
  logic [IW-1:0] owner_q, rr_ptr_q, rr_ptr_d, pick_idx;
  logic [N_CLIENTS-1:0] grant_q;
  logic pick_found, drawing, owner_done, owner_valid;
  logic pix_we_q;
  logic [X_W-1:0] pix_x_q;
  logic [Y_W-1:0] pix_y_q;
  logic [COLOR_W-1:0] pix_color_q;

  vga_draw_arbiter_rr_pick #(.N(N_CLIENTS), .IW(IW)) u_pick (
    .req_i(dbus.req),
    .ptr_i(rr_ptr_q),
    .found_o(pick_found),
    .idx_o(pick_idx)
  );

  assign drawing = (state_q == STARTUP) || (state_q == GRANT);
  assign owner_done = dbus.done[owner_q];
  assign owner_valid = dbus.valid[owner_q];
  assign rr_ptr_d = IW'(wrap_inc(int'(owner_q), N_CLIENTS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_ptr_q <= '0;
      grant_q <= '0;
      pix_we_q <= 1'b0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      pix_color_q <= '0;
    end else begin
      pix_we_q <= drawing && owner_valid;
      if (drawing && owner_valid) begin
        pix_x_q <= dbus.x_in[int'(owner_q)*X_W +: X_W];
        pix_y_q <= dbus.y_in[int'(owner_q)*Y_W +: Y_W];
        pix_color_q <= dbus.color_in[int'(owner_q)*COLOR_W +: COLOR_W];
      end
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= STARTUP;
          owner_q <= IW'(STARTUP_CLIENT);
          grant_q <= N_CLIENTS'(1) << STARTUP_CLIENT;
        end
        ARB: if (pick_found) begin
          state_q <= GRANT;
          owner_q <= pick_idx;
          grant_q <= N_CLIENTS'(1) << pick_idx;
        end
        STARTUP, GRANT: if (owner_done) begin
          state_q <= ARB;
          grant_q <= '0;
          rr_ptr_q <= rr_ptr_d;
        end
      endcase
    end
  end

  assign dbus.grant = grant_q;
  assign dbus.owner = owner_q;
  assign dbus.busy = state_q != IDLE;
  assign dbus.pix_we = pix_we_q;
  assign dbus.pix_x = pix_x_q;
  assign dbus.pix_y = pix_y_q;
  assign dbus.pix_color = pix_color_q;
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter: directed scenarios for startup, round-robin, hold and reset
module tb_vga_draw_arbiter;
  localparam int N = 4;
  localparam int XW = 11;
  localparam int YW = 11;
  localparam int CW = 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  int tests = 0;
  int fails = 0;

  vga_draw_arbiter_if #(.N_CLIENTS(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW)) bif ();

  vga_draw_arbiter #(.N_CLIENTS(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW), .STARTUP_CLIENT(0)) dut (
    .clk(clk),
    .reset(reset),
    .start_i(start),
    .dbus(bif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int i, input int x, input int y, input int c);
    bif.x_in[i*XW +: XW] = XW'(x);
    bif.y_in[i*YW +: YW] = YW'(y);
    bif.color_in[i*CW +: CW] = CW'(c);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests++; if (bif.grant !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b want 0000", bif.grant); end
    tests++; if (bif.owner !== 2'd0) begin fails++; $display("FAIL reset_owner: got %0d want 0", bif.owner); end
    tests++; if (bif.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bif.busy); end
    tests++; if (bif.pix_we !== 1'b0 || bif.pix_x !== 11'd0 || bif.pix_y !== 11'd0 || bif.pix_color !== 1'b0) begin
      fails++; $display("FAIL reset_pix: got we=%b x=%0d y=%0d c=%b want 0,0,0,0", bif.pix_we, bif.pix_x, bif.pix_y, bif.pix_color);
    end
    reset = 1'b0;
    bif.done = 4'b0001;
    tick();
    bif.done = 4'b0000;
    tests++; if (bif.busy !== 1'b0) begin fails++; $display("FAIL idle_no_start: busy got %b want 0", bif.busy); end
  endtask

  task automatic test_startup();
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (bif.grant !== 4'b0001 || bif.busy !== 1'b1) begin
      fails++; $display("FAIL startup_enter: grant=%b busy=%b want 0001,1", bif.grant, bif.busy);
    end
    bif.req = 4'b0100;
    bif.valid = 4'b0001;
    set_pix(0, 5, 7, 1);
    tick();
    bif.valid = 4'b0000;
    tests++; if (bif.pix_we !== 1'b1 || bif.pix_x !== 11'd5 || bif.pix_y !== 11'd7 || bif.pix_color !== 1'b1) begin
      fails++; $display("FAIL startup_pixel: got we=%b x=%0d y=%0d c=%b want 1,5,7,1", bif.pix_we, bif.pix_x, bif.pix_y, bif.pix_color);
    end
    tests++; if (bif.grant !== 4'b0001) begin fails++; $display("FAIL startup_exclusive: grant got %b want 0001", bif.grant); end
    bif.done = 4'b0001;
    tick();
    bif.done = 4'b0000;
    tests++; if (bif.grant !== 4'b0000 || bif.busy !== 1'b1 || bif.pix_we !== 1'b0) begin
      fails++; $display("FAIL startup_release: grant=%b busy=%b we=%b want 0000,1,0", bif.grant, bif.busy, bif.pix_we);
    end
    tests++; if (bif.pix_x !== 11'd5) begin fails++; $display("FAIL pix_hold: x got %0d want 5", bif.pix_x); end
    tick();
    tests++; if (bif.grant !== 4'b0100 || bif.owner !== 2'd2) begin
      fails++; $display("FAIL pending_grant: grant=%b owner=%0d want 0100,2", bif.grant, bif.owner);
    end
    bif.req = 4'b0000;
    bif.done = 4'b0100;
    tick();
    bif.done = 4'b0000;
    tests++; if (bif.grant !== 4'b0000) begin fails++; $display("FAIL client2_release: grant got %b want 0000", bif.grant); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp [4];
    exp[0] = 4'b1000;
    exp[1] = 4'b0010;
    exp[2] = 4'b0100;
    exp[3] = 4'b1000;
    bif.req = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (bif.grant !== exp[i]) begin fails++; $display("FAIL rr_grant[%0d]: got %b want %b", i, bif.grant, exp[i]); end
      bif.done = exp[i];
      tick();
      bif.done = 4'b0000;
      tests++; if (bif.grant !== 4'b0000) begin fails++; $display("FAIL rr_gap[%0d]: got %b want 0000", i, bif.grant); end
    end
  endtask

  task automatic test_hold();
    tick();
    tests++; if (bif.grant !== 4'b0010 || bif.owner !== 2'd1) begin
      fails++; $display("FAIL hold_grant: grant=%b owner=%0d want 0010,1", bif.grant, bif.owner);
    end
    bif.req = 4'b0000;
    bif.done = 4'b1000;
    bif.valid = 4'b1000;
    set_pix(3, 9, 9, 0);
    tick();
    bif.done = 4'b0000;
    bif.valid = 4'b0000;
    tests++; if (bif.grant !== 4'b0010) begin fails++; $display("FAIL foreign_done: grant got %b want 0010", bif.grant); end
    tests++; if (bif.pix_we !== 1'b0) begin fails++; $display("FAIL foreign_valid: pix_we got %b want 0", bif.pix_we); end
    tick();
    tests++; if (bif.grant !== 4'b0010) begin fails++; $display("FAIL req_drop_hold: grant got %b want 0010", bif.grant); end
  endtask

  task automatic test_last_pixel();
    set_pix(1, 639, 479, 1);
    bif.valid = 4'b0010;
    bif.done = 4'b0010;
    tick();
    bif.valid = 4'b0000;
    bif.done = 4'b0000;
    tests++; if (bif.pix_we !== 1'b1 || bif.pix_x !== 11'd639 || bif.pix_y !== 11'd479 || bif.pix_color !== 1'b1) begin
      fails++; $display("FAIL last_pixel: got we=%b x=%0d y=%0d c=%b want 1,639,479,1", bif.pix_we, bif.pix_x, bif.pix_y, bif.pix_color);
    end
    tests++; if (bif.grant !== 4'b0000) begin fails++; $display("FAIL last_release: grant got %b want 0000", bif.grant); end
    tick();
    tests++; if (bif.pix_we !== 1'b0 || bif.pix_x !== 11'd639 || bif.owner !== 2'd1 || bif.busy !== 1'b1) begin
      fails++; $display("FAIL arb_idle_hold: we=%b x=%0d owner=%0d busy=%b want 0,639,1,1", bif.pix_we, bif.pix_x, bif.owner, bif.busy);
    end
  endtask

  task automatic test_reset_mid_grant();
    bif.req = 4'b0001;
    tick();
    bif.req = 4'b0000;
    tests++; if (bif.grant !== 4'b0001) begin fails++; $display("FAIL wrap_grant: got %b want 0001", bif.grant); end
    bif.valid = 4'b0001;
    set_pix(0, 100, 200, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bif.valid = 4'b0000;
    tests++; if (bif.pix_we !== 1'b0 || bif.grant !== 4'b0000 || bif.busy !== 1'b0 || bif.owner !== 2'd0 || bif.pix_x !== 11'd0) begin
      fails++; $display("FAIL mid_reset: we=%b grant=%b busy=%b owner=%0d x=%0d want 0,0000,0,0,0", bif.pix_we, bif.grant, bif.busy, bif.owner, bif.pix_x);
    end
    bif.req = 4'b0100;
    tick();
    tick();
    tests++; if (bif.busy !== 1'b0 || bif.grant !== 4'b0000) begin
      fails++; $display("FAIL need_start: busy=%b grant=%b want 0,0000", bif.busy, bif.grant);
    end
    start = 1'b1;
    tick();
    tests++; if (bif.busy !== 1'b1 || bif.grant !== 4'b0001) begin
      fails++; $display("FAIL restart: busy=%b grant=%b want 1,0001", bif.busy, bif.grant);
    end
    tick();
    start = 1'b0;
    tests++; if (bif.grant !== 4'b0001) begin fails++; $display("FAIL start_ignored: grant got %b want 0001", bif.grant); end
  endtask

  initial begin
    bif.req = '0;
    bif.done = '0;
    bif.valid = '0;
    bif.x_in = '0;
    bif.y_in = '0;
    bif.color_in = '0;
    test_reset();
    test_startup();
    test_round_robin();
    test_hold();
    test_last_pixel();
    test_reset_mid_grant();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
